// File: rtl/piso_seq_ctrl_pkg.sv
// Shared types for the PISO sequencing controller.
// State encoding and counter sizing helper.
package piso_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Counter width for a count range of n values, never below 1 bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load shift register, MSB out, zero fill.
// Clear wins over load, load wins over shift.
module piso_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/piso_seq_ctrl.sv
// Framing and pacing controller around piso_shreg.
// Accepts a word, shifts it MSB-first, then enforces a gap.
module piso_seq_ctrl
   import piso_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shift_en,
   input  logic             abort,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_first,
   output logic             sout_last,
   output logic             frame_done,
   output logic             busy
);

   localparam int BW = cnt_w(WIDTH);
   localparam int GW = cnt_w(GAP + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_t        state;
   logic [BW-1:0] bitcnt;
   logic [GW-1:0] gapcnt;
   logic          live;
   logic          done_q;
   logic          msb;
   logic          take;
   logic          at_last;
   logic          in_shift;

   assign in_shift   = (state == S_SHIFT);
   assign at_last    = (bitcnt == BIT_LAST);
   // live keeps in_ready low until the first edge after reset release
   assign in_ready   = live & (state == S_IDLE);
   assign take       = in_valid & in_ready;
   assign sout_valid = in_shift;
   assign sout       = in_shift & msb;
   assign sout_first = in_shift & (bitcnt == '0);
   assign sout_last  = in_shift & at_last;
   assign frame_done = done_q;
   assign busy       = (state != S_IDLE);

   piso_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk  (clk),
      .rst  (rst),
      .load (take),
      .shift(in_shift & shift_en & ~abort & ~at_last),
      .clr  (abort & busy),
      .din  (in_data),
      .msb  (msb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         bitcnt <= '0;
         gapcnt <= '0;
         done_q <= 1'b0;
         live   <= 1'b0;
      end else begin
         live   <= 1'b1;
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (take) begin
                  state  <= S_SHIFT;
                  bitcnt <= '0;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (shift_en) begin
                  if (at_last) begin
                     done_q <= 1'b1;
                     gapcnt <= '0;
                     state  <= (GAP > 0) ? S_GAP : S_IDLE;
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (shift_en) begin
                  if (gapcnt == GAP_LAST) begin
                     state <= S_IDLE;
                  end else begin
                     gapcnt <= gapcnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Scoreboard bench for piso_seq_ctrl: GAP=2 and GAP=0 instances.
// Stimulus pushes expected bits, a negedge monitor pops and compares.
module tb_piso_seq_ctrl;

   typedef struct packed {
      logic b;
      logic f;
      logic l;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [1:0] iv = 2'b00;
   logic       shift_en = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] rdy, so, sv, sf, sl, fd, bz;

   int   total = 0;
   int   bad = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [1:0] pend = 2'b00;

   piso_seq_ctrl #(.WIDTH(8), .GAP(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (iv[0]),
      .in_ready  (rdy[0]),
      .shift_en  (shift_en),
      .abort     (abort),
      .sout      (so[0]),
      .sout_valid(sv[0]),
      .sout_first(sf[0]),
      .sout_last (sl[0]),
      .frame_done(fd[0]),
      .busy      (bz[0])
   );

   piso_seq_ctrl #(.WIDTH(8), .GAP(0)) dut_g0 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (iv[1]),
      .in_ready  (rdy[1]),
      .shift_en  (shift_en),
      .abort     (abort),
      .sout      (so[1]),
      .sout_valid(sv[1]),
      .sout_first(sf[1]),
      .sout_last (sl[1]),
      .frame_done(fd[1]),
      .busy      (bz[1])
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endfunction

   function automatic void push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic int qn(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qf(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void qpop(input int d);
      if (d == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
   endfunction

   function automatic void qclr(input int d);
      if (d == 0) q0.delete();
      else q1.delete();
   endfunction

   // Monitor: every valid cycle must match the queue head
   always @(negedge clk) begin
      exp_t e;
      logic ed;
      if (!rst) begin
         q0.delete();
         q1.delete();
         pend = 2'b00;
      end else begin
         for (int d = 0; d < 2; d++) begin
            ed = pend[d];
            pend[d] = 1'b0;
            chk($sformatf("frame_done[%0d]", d), int'(fd[d]), int'(ed));
            if (sv[d]) begin
               if (qn(d) == 0) begin
                  chk($sformatf("unexpected_bit[%0d]", d), 1, 0);
               end else begin
                  e = qf(d);
                  chk($sformatf("bit_first_last[%0d]", d),
                      int'({so[d], sf[d], sl[d]}), int'(e));
                  if (abort) begin
                     qclr(d);
                  end else if (shift_en) begin
                     qpop(d);
                     if (e.l) pend[d] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic accept(input int d, input logic [7:0] w, output int cyc);
      in_data = w;
      iv[d] = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!rdy[d] && cyc < 100);
      chk("accept_ready", int'(rdy[d]), 1);
      if (rdy[d]) begin
         for (int i = 7; i >= 0; i--) begin
            push(d, exp_t'({w[i], i == 7, i == 0}));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int d);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fd[d] && n < 100);
      chk("done_seen", int'(fd[d]), 1);
   endtask

   task automatic wait_ready(input int d);
      int n;
      n = 0;
      while (!rdy[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_ready", int'(rdy[d]), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int c;
      int n;
      int run;
      int cnt;

      // reset with in_valid asserted
      iv = 2'b11;
      in_data = 8'h5A;
      shift_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready0", int'(rdy[0]), 0);
      chk("rst_in_ready1", int'(rdy[1]), 0);
      chk("rst_sout_valid", int'(sv[0]), 0);
      chk("rst_busy", int'(bz[0]), 0);
      iv = 2'b00;
      #1 rst = 1'b1;
      #1 chk("ready_before_edge", int'(rdy[0]), 0);
      @(negedge clk);
      chk("ready_after_release0", int'(rdy[0]), 1);
      chk("ready_after_release1", int'(rdy[1]), 1);
      @(posedge clk);
      #1;

      // basic frame A5, GAP=2
      shift_en = 1'b1;
      accept(0, 8'hA5, c);
      iv[0] = 1'b0;
      wait_done(0);
      chk("ready_during_gap", int'(rdy[0]), 0);
      n = 0;
      while (!rdy[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("gap_cycles", n, 2);
      @(posedge clk);
      #1;

      // pacing: one shift_en every third cycle
      shift_en = 1'b0;
      accept(0, 8'h81, c);
      iv[0] = 1'b0;
      run = 0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         shift_en = (i % 3 == 2);
         @(negedge clk);
         if (sv[0]) cnt++;
         if (sv[0] && run == i) run++;
         @(posedge clk);
         #1;
      end
      chk("paced_valid_run", run, 24);
      chk("paced_valid_total", cnt, 24);
      shift_en = 1'b1;
      wait_ready(0);

      // back-to-back on GAP=0 instance
      accept(1, 8'hFF, c);
      accept(1, 8'h00, c);
      chk("b2b_spacing", c, 9);
      iv[1] = 1'b0;
      wait_done(1);
      wait_ready(1);

      // abort after three bits
      accept(0, 8'hF0, c);
      iv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_ready", int'(rdy[0]), 1);
      chk("abort_sout_valid", int'(sv[0]), 0);
      chk("abort_busy", int'(bz[0]), 0);
      // abort in IDLE must not block a handshake
      abort = 1'b1;
      accept(0, 8'h0F, c);
      abort = 1'b0;
      iv[0] = 1'b0;
      chk("idle_abort_busy", int'(bz[0]), 1);
      wait_done(0);
      wait_ready(0);

      // async reset mid-frame
      accept(0, 8'hC3, c);
      iv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_sout_valid", int'(sv[0]), 0);
      chk("arst_busy", int'(bz[0]), 0);
      chk("arst_ready", int'(rdy[0]), 0);
      chk("arst_sout", int'(so[0]), 0);
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("arst_release_ready", int'(rdy[0]), 1);
      repeat (5) @(negedge clk);
      chk("queues_empty", q0.size() + q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/piso_seq_ctrl.md
Name: piso_seq_ctrl

Overview:
Sequencing controller for the parallel-in/serial-out shift path. It accepts a parallel word through a valid/ready handshake and loads it into an internal shift register. It then shifts the word out MSB-first, one bit per shift_en strobe, and enforces a programmable inter-frame gap. It sits between a word producer and any serial consumer (line driver, bit-banged link) that needs framing markers and pacing.

Parameters:
WIDTH, 8, bits per frame; legal range 2..32.
GAP, 1, idle shift_en ticks between the end of one frame and the next in_ready; 0 allowed.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-low reset (0 = reset asserted); single clock domain.
in_data  input  WIDTH  parallel word to serialize.
in_valid  input  1  producer has a word.
in_ready  output  1  controller can accept a word this cycle.
shift_en  input  1  pacing strobe; one bit advances per cycle where shift_en=1.
abort  input  1  synchronous frame abort.
sout  output  1  serial data, MSB first.
sout_valid  output  1  sout carries a frame bit.
sout_first  output  1  sout is bit WIDTH-1 (first bit) of the frame.
sout_last  output  1  sout is bit 0 (last bit) of the frame.
frame_done  output  1  one-cycle pulse when the last bit is consumed.
busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, SHIFT, GAP. Width of bit counter = clog2(WIDTH); gap counter = clog2(GAP+1) (min 1 bit).
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, counters=0, frame_done=0. While rst=0 all outputs are 0, including in_ready. in_ready rises only after rst is released.
- IDLE: in_ready=1, sout_valid=0, sout=0. A transfer occurs at the clk edge where in_valid=1 and in_ready=1: shreg<=in_data, bitcnt<=0, state<=SHIFT. in_data is not sampled in any other state.
- SHIFT: in_ready=0, sout_valid=1, sout=shreg[WIDTH-1].
  - sout_first=(bitcnt==0); sout_last=(bitcnt==WIDTH-1). Both are combinational from registered state.
  - When shift_en=1 and bitcnt<WIDTH-1: shreg<=shreg<<1 with 0 fill, and bitcnt increments.
  - When shift_en=1 and bitcnt==WIDTH-1: frame_done=1 for the following cycle (registered pulse). State goes to GAP with gapcnt<=0 if GAP>0, otherwise to IDLE.
  - When shift_en=0: everything holds; the bit stays on sout indefinitely.
- Each bit is presented for at least one full cycle. The first bit is visible the cycle after the handshake, regardless of shift_en.
- GAP: sout_valid=0, in_ready=0. gapcnt increments on each shift_en. On the shift_en where gapcnt==GAP-1, state goes to IDLE.
- Minimum spacing: in_ready is asserted only in IDLE, so there is at least one cycle between frames even when GAP=0. Back-to-back words cost WIDTH ticks + GAP ticks + 1 cycle.
- abort=1 in SHIFT or GAP: state<=IDLE next edge, shreg<=0, no frame_done. abort has priority over shift_en. abort in IDLE has no effect and does not block a concurrent handshake.
- in_valid deasserted mid-frame: ignored. in_data changing mid-frame: ignored, because the shift register holds a private copy.
- Reset asserted mid-frame: immediate return to the reset state; the partial frame is lost and no frame_done is produced.
- shift_en during IDLE: ignored.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2) and a WIDTH-to-counter-width helper function.
- One sub-module, piso_shreg: WIDTH-bit register with load, shift-enable and clear inputs; async active-low rst; serial output = MSB.
- The controller holds the FSM, the counters and the framing outputs, and drives the piso_shreg controls.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> in_ready=0, sout_valid=0, busy=0. Release -> in_ready=1 next cycle.
- Basic frame, WIDTH=8, GAP=2, shift_en=1 constantly, in_data=8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles. sout_first on bit 1 only, sout_last on bit 8 only. One frame_done pulse, then 2 GAP cycles, then in_ready=1.
- Pacing: shift_en asserted every 3rd cycle, in_data=8'h81 -> each bit held for 3 cycles; bit order 1,0,0,0,0,0,0,1; sout_valid high continuously for 24 cycles.
- Back-to-back, GAP=0: in_valid held high with 8'hFF then 8'h00 -> second handshake occurs exactly 1 IDLE cycle after the last bit of the first frame; the second frame is all 0s.
- Abort: in_data=8'hF0, abort=1 after 3 bits -> next cycle IDLE, in_ready=1, no frame_done, sout_valid=0. The next word 8'h0F serializes cleanly.
- Async reset mid-frame: drop rst at bit 5 -> outputs clear without waiting for a clk edge. After release, no frame_done and in_ready=1.
